// File: rtl/mult_seq_pkg.sv
// Shared constants and state encoding for the sequential shift-add multiplier.
package mult_seq_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/mult_add.sv
// Combinational W-bit adder with carry-out used by each shift-add iteration.
module mult_add #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         co
);

    assign {co, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mult_seq.sv
// Sequential 32x32 -> 64 multiplier: one shift-add step per cycle, fixed 33-cycle latency.
// Signed operation is compiled in only when MULT_SEQ_SIGNED_EN is defined.
module mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cancel,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Signed,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Zero
);

    import mult_seq_pkg::*;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     m;
    logic [WIDTH-1:0]     acc_hi;
    logic [WIDTH-1:0]     acc_lo;
    logic                 neg;

    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic                 neg_in;
    logic [WIDTH-1:0]     add_b;
    logic [WIDTH-1:0]     sum;
    logic                 c;
    logic [2*WIDTH-1:0]   result;

`ifdef MULT_SEQ_SIGNED_EN
    // Magnitudes stay unsigned, so -2^31 maps to 0x80000000 without overflow.
    assign abs_a  = (Signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
    assign abs_b  = (Signed && B[WIDTH-1]) ? (~B + 1'b1) : B;
    assign neg_in = Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
`else
    logic unused_signed;
    assign unused_signed = Signed;
    assign abs_a  = A;
    assign abs_b  = B;
    assign neg_in = 1'b0;
`endif

    assign add_b = acc_lo[0] ? m : '0;

    mult_add #(.W(WIDTH)) u_add (
        .a   (acc_hi),
        .b   (add_b),
        .sum (sum),
        .co  (c)
    );

    assign result = neg ? (~{acc_hi, acc_lo} + 1'b1) : {acc_hi, acc_lo};
    assign busy   = (state != IDLE);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would chain the shift-add steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            m      <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            neg    <= 1'b0;
            done   <= 1'b0;
            HI     <= '0;
            LO     <= '0;
            Zero   <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        m      <= abs_a;
                        acc_hi <= '0;
                        acc_lo <= abs_b;
                        neg    <= neg_in;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (cancel) begin
                        state <= IDLE;
                    end else begin
                        // {c,sum,acc_lo} >> 1, truncated to 64 bits
                        acc_hi <= {c, sum[WIDTH-1:1]};
                        acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
                        cnt    <= cnt + 1'b1;
                        if (cnt == CNT_W'(ITER - 1)) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (!cancel) begin
                        HI   <= result[2*WIDTH-1:WIDTH];
                        LO   <= result[WIDTH-1:0];
                        Zero <= (result == '0);
                        done <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
